// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serves icache and dcache requests on one single-ported RAM,
// with bounded data-over-instruction priority, a RAM timeout and error reporting.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam int unsigned STRK_W = $clog2(MAX_DSTREAK + 1);
    localparam int unsigned TMO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERV  = 2'd1,
        DREAD  = 2'd2,
        DWRITE = 2'd3
    } state_t;

    state_t              r_state;
    logic [STRK_W-1:0]   r_streak;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_ramREN;
    logic                r_ramWEN;
    logic [31:0]         r_ramaddr;
    logic [31:0]         r_ramstore;
    logic [31:0]         r_iload;
    logic [31:0]         r_dload;
    logic                r_mem_err;

    logic                w_serv;
    logic                w_access;
    logic                w_error;
    logic                w_tmo;
    logic                w_done;
    logic                w_fail;
    logic                w_dreq;
    logic                w_streak_max;
    logic                w_igrant;
    logic                w_dgrant;
    logic [STRK_W-1:0]   w_streak_inc;

    assign w_serv       = (r_state != IDLE);
    assign w_access     = (ramstate == RS_ACCESS);
    assign w_error      = (ramstate == RS_ERROR);
    assign w_tmo        = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    assign w_done       = w_serv && (w_access || w_error || w_tmo);
    // A completion that did not see ACCESS is an error completion.
    assign w_fail       = w_done && !w_access;

    // Instruction port wins only when data is idle or the data streak is exhausted.
    assign w_dreq       = dREN || dWEN;
    assign w_streak_max = (r_streak == STRK_W'(MAX_DSTREAK));
    assign w_igrant     = iREN && (!w_dreq || w_streak_max);
    assign w_dgrant     = w_dreq && !w_igrant;
    assign w_streak_inc = w_streak_max ? r_streak : r_streak + STRK_W'(1);

    assign iwait    = !((r_state == ISERV) && w_done);
    assign dwait    = !(((r_state == DREAD) || (r_state == DWRITE)) && w_done);
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign mem_err  = r_mem_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_streak   <= '0;
            r_tmo      <= '0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_iload    <= '0;
            r_dload    <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= w_fail;
            case (r_state)
                IDLE: begin
                    r_tmo <= '0;
                    if (w_igrant) begin
                        r_state    <= ISERV;
                        r_ramREN   <= 1'b1;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= iaddr;
                        r_ramstore <= '0;
                        r_streak   <= '0;
                    end else if (w_dgrant) begin
                        r_ramaddr <= daddr;
                        r_streak  <= iREN ? w_streak_inc : '0;
                        if (dWEN) begin
                            r_state    <= DWRITE;
                            r_ramREN   <= 1'b0;
                            r_ramWEN   <= 1'b1;
                            r_ramstore <= dstore;
                        end else begin
                            r_state    <= DREAD;
                            r_ramREN   <= 1'b1;
                            r_ramWEN   <= 1'b0;
                            r_ramstore <= '0;
                        end
                    end else if (!iREN) begin
                        r_streak <= '0;
                    end
                end
                default: begin
                    // Service: strobes and address hold until a completion condition.
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_tmo      <= '0;
                        r_ramREN   <= 1'b0;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= '0;
                        r_ramstore <= '0;
                        if (r_state == ISERV) begin
                            r_iload <= w_access ? ramload : ERR_WORD;
                        end
                        if (r_state == DREAD) begin
                            r_dload <= w_access ? ramload : ERR_WORD;
                        end
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the RAM is driven directly by the bench.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] exp_addr [6] = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    int          k;

    initial begin
        nRST = 1'b0; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
        nxt(); nxt(); settle();
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        nxt(); nRST = 1'b1;

        // icache read with 3 BUSY cycles then ACCESS
        nxt(); iREN = 1; iaddr = 32'h40; ramstate = BUSY; settle();
        chk("t1_idle_ren", 32'(ramREN), 0);
        nxt(); settle();
        chk("t1_c1_ren", 32'(ramREN), 1);
        chk("t1_c1_addr", ramaddr, 32'h40);
        chk("t1_c1_iwait", 32'(iwait), 1);
        nxt(); nxt(); settle();
        chk("t1_c3_ren", 32'(ramREN), 1);
        chk("t1_c3_iwait", 32'(iwait), 1);
        nxt(); ramstate = ACCESS; ramload = 32'h8C220004; settle();
        chk("t1_c4_iwait", 32'(iwait), 0);
        chk("t1_c4_dwait", 32'(dwait), 1);
        chk("t1_c4_addr", ramaddr, 32'h40);
        nxt(); iREN = 0; ramstate = FREE; settle();
        chk("t1_iload", iload, 32'h8C220004);
        chk("t1_iwait_after", 32'(iwait), 1);
        chk("t1_ren_after", 32'(ramREN), 0);

        // simultaneous iREN/dREN, zero-wait RAM: data first
        nxt(); iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'h11112222;
        nxt(); settle();
        chk("t2_d_addr", ramaddr, 32'h200);
        chk("t2_d_waits", {30'd0, iwait, dwait}, 32'b10);
        nxt(); dREN = 0; ramload = 32'h33334444; settle();
        chk("t2_dload", dload, 32'h11112222);
        chk("t2_gap_waits", {30'd0, iwait, dwait}, 32'b11);
        nxt(); settle();
        chk("t2_i_addr", ramaddr, 32'h100);
        chk("t2_i_waits", {30'd0, iwait, dwait}, 32'b01);
        nxt(); iREN = 0; settle();
        chk("t2_iload", iload, 32'h33334444);

        // back-to-back data with iREN pending: 4 data, 1 instr, data again
        nxt(); iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h400;
        ramstate = ACCESS; ramload = 32'h55556666; settle();
        for (int g = 0; g < 6; g++) begin
            nxt(); settle();
            chk($sformatf("t3_grant%0d_addr", g), ramaddr, exp_addr[g]);
            chk($sformatf("t3_grant%0d_waits", g), {30'd0, iwait, dwait},
                (g == 4) ? 32'b01 : 32'b10);
            nxt();
        end
        iREN = 0; dREN = 0; settle();
        chk("t3_idle_ren", 32'(ramREN), 0);

        // write, with dREN also high: treated as a write
        nxt(); dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF; ramstate = BUSY;
        nxt(); settle();
        chk("t4_wen", {30'd0, ramREN, ramWEN}, 32'b01);
        chk("t4_store", ramstore, 32'hDEADBEEF);
        chk("t4_addr", ramaddr, 32'h80);
        chk("t4_busy_dwait", 32'(dwait), 1);
        nxt(); ramstate = ACCESS; ramload = 32'h77778888; settle();
        chk("t4_dwait", 32'(dwait), 0);
        nxt(); dWEN = 0; dREN = 0; ramstate = FREE; settle();
        chk("t4_dload_kept", dload, 32'h55556666);
        chk("t4_wen_after", 32'(ramWEN), 0);
        chk("t4_merr", 32'(mem_err), 0);

        // timeout: RAM stuck BUSY on an icache read
        nxt(); iREN = 1; iaddr = 32'h48; ramstate = BUSY;
        k = 0;
        for (int n = 1; n <= 100; n++) begin
            nxt(); settle();
            if (iwait === 1'b0) begin
                k = n;
                break;
            end
        end
        chk("t5_tmo_cycle", k, 64);
        chk("t5_tmo_addr", ramaddr, 32'h48);
        chk("t5_tmo_merr_early", 32'(mem_err), 0);
        nxt(); iREN = 0; ramstate = FREE; settle();
        chk("t5_tmo_merr", 32'(mem_err), 1);
        chk("t5_tmo_iload", iload, 32'hBAD1BAD1);
        nxt(); settle();
        chk("t5_tmo_merr_once", 32'(mem_err), 0);

        // RAM ERROR on an icache read
        iREN = 1; iaddr = 32'h44; ramstate = BUSY;
        nxt(); ramstate = ERROR; settle();
        chk("t6_err_waits", {30'd0, iwait, dwait}, 32'b01);
        nxt(); iREN = 0; ramstate = FREE; settle();
        chk("t6_err_merr", 32'(mem_err), 1);
        chk("t6_err_iload", iload, 32'hBAD1BAD1);
        nxt(); settle();
        chk("t6_err_merr_once", 32'(mem_err), 0);

        // reset in the middle of a BUSY data read
        nxt(); dREN = 1; daddr = 32'h500; ramstate = BUSY;
        nxt(); settle();
        chk("t7_ren_before", 32'(ramREN), 1);
        nxt(); nRST = 0; settle();
        chk("t7_rst_strobes", {30'd0, ramREN, ramWEN}, 0);
        chk("t7_rst_dwait", 32'(dwait), 1);
        chk("t7_rst_dload", dload, 0);
        chk("t7_rst_iload", iload, 0);
        chk("t7_rst_merr", 32'(mem_err), 0);
        nxt(); dREN = 0; nRST = 1; settle();
        chk("t7_rel_merr", 32'(mem_err), 0);
        nxt(); dREN = 1; daddr = 32'h600; ramstate = ACCESS; ramload = 32'h9999AAAA;
        nxt(); settle();
        chk("t7_new_addr", ramaddr, 32'h600);
        chk("t7_new_dwait", 32'(dwait), 0);
        nxt(); dREN = 0; settle();
        chk("t7_new_dload", dload, 32'h9999AAAA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache request protocol (iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload).
- Arbitrates icache and dcache requests onto a single-ported RAM and returns wait/load responses.
- Provides bounded data-over-instruction priority, a RAM timeout, and error reporting.
- Sits between the cache pair and the RAM model in the pipelined processor.

Parameters:
- MAX_DSTREAK, 4: consecutive data grants allowed while iREN is pending before the instruction port is forced a grant.
- TIMEOUT_CYC, 64: service cycles without ramstate ACCESS before a forced error completion.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an error or timeout completion.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low; clock CLK
- iREN  in  1  icache read request
- iaddr  in  32  icache address
- iwait  out  1  low = icache request completes this cycle
- iload  out  32  icache read data (registered)
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  low = dcache request completes this cycle
- dload  out  32  dcache read data (registered)
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- mem_err  out  1  one-cycle pulse on an error or timeout completion

Behaviour:
- Reset values: state IDLE; iwait=1, dwait=1; iload=0, dload=0; ramREN/ramWEN=0; ramaddr/ramstore=0; mem_err=0; streak and timeout counters=0. Reset asserted mid-transaction aborts it at once; no completion is signalled.
- States: IDLE, ISERV, DREAD, DWRITE.
- IDLE: arbitration.
  - dWEN has priority over dREN (dWEN&dREN together is treated as a write).
  - Data port beats the instruction port unless iREN=1 and streak==MAX_DSTREAK, in which case ISERV is chosen.
  - On grant, the address (and dstore for a write) is latched; the service state is entered next cycle.
  - No request keeps the arbiter in IDLE.
- Service states:
  - ramaddr = latched address; ramstore = latched data in DWRITE, else 0.
  - ramREN=1 in ISERV and DREAD; ramWEN=1 in DWRITE. Strobes are 0 in IDLE.
  - The timeout counter increments each service cycle.
- Completion happens in the service cycle where any of these holds: ramstate==ACCESS, ramstate==ERROR, or timeout counter==TIMEOUT_CYC-1.
  - The granted port's wait goes low combinationally in that cycle only; the other wait stays 1.
  - For reads, the load register captures ramload (ACCESS) or ERR_WORD (ERROR or timeout) at that edge; iload/dload then hold it until the next completion on that port.
  - mem_err pulses in the cycle after an ERROR or timeout completion.
  - The next state is IDLE; the timeout counter clears.
- Latency: a request seen in IDLE at cycle 0 gets strobes at cycle 1. If ACCESS occurs at cycle 1, wait is low at cycle 1, load is valid from cycle 2, and the arbiter is in IDLE at cycle 2.
- Requester rule: a request is held stable until its wait is low and is dropped the following cycle. The arbiter does not filter stale requests.
- Streak counter:
  - Increments on a data grant while iREN=1, saturating at MAX_DSTREAK.
  - Clears on an instruction grant, or on any IDLE cycle with iREN=0.
- ramstate BUSY/FREE in service: stay and hold all strobes and address stable.
- Write completions leave dload unchanged.

Test Plan:
- Icache read @0x40, RAM gives ACCESS after 3 BUSY cycles with ramload=0x8C220004 -> ramREN=1 for 4 cycles with ramaddr=0x40; iwait low in 4th service cycle only; iload=0x8C220004 from the next cycle; dwait stays 1.
- iREN and dREN raised together, addresses 0x100/0x200, zero-wait RAM -> data served first (ramaddr 0x200), then instruction; each wait low exactly once.
- Continuous back-to-back dREN with iREN pending, MAX_DSTREAK=4 -> exactly 4 data grants, then 1 instruction grant, then the streak restarts.
- dWEN @0x80, dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, ramREN=0; dwait low on ACCESS; dload unchanged.
- RAM returns ERROR on an icache read -> iwait low that cycle; iload=0xBAD1BAD1; mem_err pulses once. With ramstate held BUSY -> completion at service cycle 64 with the same response.
- nRST asserted during DREAD in a BUSY cycle -> strobes drop to 0 immediately; dwait=1; dload=0; no mem_err pulse; the arbiter accepts a fresh request after release.
